vector_multiply_pipeline: RTL and testbench
===========================================

Name: vector_multiply_pipeline

Overview:
Pipelined, parametrised SIMD integer multiplier for the vector execution cluster. It supports per-operation element width (8/16/32/64), signedness, widening and high-half selection. Operands enter and results leave through valid/ready handshakes, with a flush for squashed instructions. It replaces the purely combinational multiplier so the product path can be retimed across PIPE_STAGES registers at full throughput.

Parameters:
DATA_WIDTH, 64, operand/result width in bits; legal values 32 or 64.
PIPE_STAGES, 3, register stages from input acceptance to output; minimum 1.
TAG_WIDTH, 6, width of the opaque instruction tag carried alongside the data.

Ports:
clk  input  1  clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
flush  input  1  discard all in-flight operations.
in_valid  input  1  operation present.
in_ready  output  1  operation accepted when in_valid & in_ready.
in_sew  input  2  element width: 00=8, 01=16, 10=32, 11=64.
in_sign  input  2  00=unsigned*unsigned, 01=signed vs2*unsigned vs1, 10=signed*signed, 11=reserved.
in_widen  input  1  deliver full double-width products.
in_high  input  1  deliver upper half of each product (non-widening only).
in_tag  input  TAG_WIDTH  tag returned with the result.
vs2  input  DATA_WIDTH  multiplicand.
vs1  input  DATA_WIDTH  multiplier.
out_valid  output  1  result present.
out_ready  input  1  consumer accepts the result.
out_vd  output  DATA_WIDTH  result, or low half of the widened result.
out_vd_high  output  DATA_WIDTH  high half of the widened result; 0 otherwise.
out_tag  output  TAG_WIDTH  tag of the presented result.

Behaviour:
- Reset (async assert, sync release): all stage valid bits cleared. out_valid=0, out_vd=0, out_vd_high=0, out_tag=0. in_ready=1 after reset.
- Pipeline advance: the pipeline advances when advance = !out_valid | out_ready. in_ready = advance (combinational). No internal bubbles are inserted, so throughput is 1 op/cycle.
- Latency: an op accepted at edge k shows out_valid=1 after edge k+PIPE_STAGES-1, given no stalls. For PIPE_STAGES=1, the result is registered at the accepting edge.
- Stall: while out_valid=1 and out_ready=0, all stages hold. out_vd, out_vd_high and out_tag stay stable. Ordering is strictly FIFO.
- Flush:
  - Clears every stage valid bit at the next edge, including an op accepted in the same cycle.
  - out_valid=0 after that edge. Data registers may retain stale values.
  - flush takes priority over in_valid and out_ready.
- Arithmetic:
  - Lane count N = DATA_WIDTH/SEW. Lane i operands are bits [SEW*i +: SEW].
  - The full product P_i has width 2*SEW.
  - Signed operands are sign-extended; unsigned operands are zero-extended.
- Result packing, widen=1: {out_vd_high,out_vd}[2*SEW*i +: 2*SEW] = P_i. in_high is ignored.
- Result packing, widen=0, high=0: out_vd lane i = P_i[SEW-1:0].
- Result packing, widen=0, high=1: out_vd lane i = P_i[2*SEW-1:SEW].
- out_vd_high = 0 whenever widen=0.
- in_sign=11, or SEW > DATA_WIDTH (sew=11 with DATA_WIDTH=32): the op still flows through the pipeline with its tag, and both result buses are 0.
- Control fields are captured at acceptance and travel with the op. Ops in flight never mix modes.

Test Plan:
- SEW8, ss, widen=0, high=0, vs2=0xFFFF_FFFF_FFFF_FFFF, vs1=0x0202_0202_0202_0202 -> out_vd=0xFEFE_FEFE_FEFE_FEFE, out_vd_high=0. Same op with high=1 -> out_vd=0xFFFF_FFFF_FFFF_FFFF.
- SEW32, uu, widen=1, vs2=vs1=0xFFFF_FFFF_FFFF_FFFF -> out_vd=0xFFFF_FFFE_0000_0001, out_vd_high=0xFFFF_FFFE_0000_0001. Same operands with ss -> out_vd=0x0000_0000_0000_0001, out_vd_high=0x0000_0000_0000_0001.
- SEW64, su, high=1, vs2=all-ones, vs1=2 -> out_vd=0xFFFF_FFFF_FFFF_FFFF. Same operands with uu -> out_vd=0x0000_0000_0000_0001.
- Stream of 6 back-to-back ops with tags 0..5; out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the stall, outputs held stable, tags emerge as 0..5 with no loss or duplication. First result at latency PIPE_STAGES.
- Fill pipeline with 3 ops, assert flush together with a new in_valid -> out_valid=0 the next cycle and none of the 4 ops emerge. The next accepted op appears after exactly PIPE_STAGES cycles.
- Assert rst_n=0 asynchronously mid-stream -> out_valid and outputs go to 0 immediately, without waiting for a clock edge. After release, in_ready=1 and a new op completes normally. Also check in_sign=11 -> tag returned with both result buses 0.

Source files
------------

// File: rtl/vector_multiply_pipeline.sv
// -----------------------------------------------------------------------------
// vector_multiply_pipeline
//
// Pipelined SIMD integer multiplier for the vector execution cluster. Each
// operation selects its element width (8/16/32/64), signedness, widening and
// high-half selection. The control fields are captured at acceptance and
// travel with the operation, so operations of different modes can be in
// flight together.
//
// The products are formed from the operands presented at the input and then
// carried through PIPE_STAGES registers. This leaves the retiming tool free to
// spread the multiplier across the stages. All stages move together whenever
// the output register is free or is being drained, which gives one operation
// per cycle with no bubbles.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   flush               drop every in-flight op, including one accepted now
//   in_valid/in_ready   input handshake; in_ready is combinational
//   in_sew              element width 00=8 01=16 10=32 11=64
//   in_sign             00=uu 01=su (vs2 signed) 10=ss 11=reserved (result 0)
//   in_widen, in_high   double-width products / upper half of each product
//   in_tag              opaque tag returned with the result
//   vs2, vs1            multiplicand, multiplier
//   out_valid/out_ready output handshake
//   out_vd, out_vd_high result (low half when widening), high half or 0
//   out_tag             tag of the presented result
// -----------------------------------------------------------------------------
module vector_multiply_pipeline #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned PIPE_STAGES = 3,
  parameter int unsigned TAG_WIDTH   = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_sew,
  input  logic [1:0]            in_sign,
  input  logic                  in_widen,
  input  logic                  in_high,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  input  logic [DATA_WIDTH-1:0] vs2,
  input  logic [DATA_WIDTH-1:0] vs1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_vd,
  output logic [DATA_WIDTH-1:0] out_vd_high,
  output logic [TAG_WIDTH-1:0]  out_tag
);

  // Full 2w-bit product of the low w bits of a and b.
  function automatic logic [127:0] lane_product(input logic [63:0] a, input logic [63:0] b,
                                                input int unsigned w, input logic a_signed,
                                                input logic b_signed);
    logic [63:0]         a_al;
    logic [63:0]         b_al;
    logic signed [64:0]  a_ext;
    logic signed [64:0]  b_ext;
    logic signed [127:0] p;
    // Left-align the lane, then shift back arithmetically: the extra top bit
    // is the lane MSB for signed operands and 0 otherwise.
    a_al  = a << (64 - w);
    b_al  = b << (64 - w);
    a_ext = $signed({a_signed & a_al[63], a_al}) >>> (64 - w);
    b_ext = $signed({b_signed & b_al[63], b_al}) >>> (64 - w);
    p     = 128'(a_ext) * 128'(b_ext);
    return p;
  endfunction

  // Packed {high, low} result for all lanes of one operation.
  function automatic logic [2*DATA_WIDTH-1:0] simd_mul(input logic [DATA_WIDTH-1:0] a,
                                                       input logic [DATA_WIDTH-1:0] b,
                                                       input logic [1:0] sew,
                                                       input logic [1:0] sign,
                                                       input logic widen, input logic high);
    logic [127:0] acc;
    logic [127:0] p;
    logic [127:0] lane;
    int unsigned  w;
    logic         a_s;
    logic         b_s;
    acc = '0;
    w   = 32'd8 << sew;
    a_s = (sign != 2'b00);
    b_s = (sign == 2'b10);
    // Reserved signedness and elements wider than the datapath yield zero.
    if (sign != 2'b11 && w <= DATA_WIDTH) begin
      for (int unsigned i = 0; i < DATA_WIDTH / 8; i++) begin
        if (i < DATA_WIDTH / w) begin
          p = lane_product(64'(a >> (w * i)), 64'(b >> (w * i)), w, a_s, b_s);
          if (widen) begin
            lane = p & ({128{1'b1}} >> (128 - 2 * w));
            acc  = acc | (lane << (2 * w * i));
          end else begin
            lane = (high ? (p >> w) : p) & ({128{1'b1}} >> (128 - w));
            acc  = acc | (lane << (w * i));
          end
        end
      end
    end
    return acc[2*DATA_WIDTH-1:0];
  endfunction

  logic                    advance;
  logic                    accept;
  logic [2*DATA_WIDTH-1:0] prod_d;

  logic [PIPE_STAGES-1:0]  valid_q;
  logic [DATA_WIDTH-1:0]   vd_q  [PIPE_STAGES];
  logic [DATA_WIDTH-1:0]   vdh_q [PIPE_STAGES];
  logic [TAG_WIDTH-1:0]    tag_q [PIPE_STAGES];

  assign out_valid   = valid_q[PIPE_STAGES-1];
  assign out_vd      = vd_q[PIPE_STAGES-1];
  assign out_vd_high = vdh_q[PIPE_STAGES-1];
  assign out_tag     = tag_q[PIPE_STAGES-1];

  // Whole pipe moves as one: no bubble collapsing, so a stall holds everything.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && advance;

  always_comb begin
    prod_d = simd_mul(vs2, vs1, in_sew, in_sign, in_widen, in_high);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int unsigned s = 0; s < PIPE_STAGES; s++) begin
        vd_q[s]  <= '0;
        vdh_q[s] <= '0;
        tag_q[s] <= '0;
      end
    end else begin
      // Flush wins over both handshakes; data may keep stale contents.
      if (flush) begin
        valid_q <= '0;
      end else if (advance) begin
        valid_q[0] <= accept;
        for (int unsigned s = 1; s < PIPE_STAGES; s++) begin
          valid_q[s] <= valid_q[s-1];
        end
      end
      if (advance) begin
        vd_q[0]  <= prod_d[DATA_WIDTH-1:0];
        vdh_q[0] <= prod_d[2*DATA_WIDTH-1:DATA_WIDTH];
        tag_q[0] <= in_tag;
        for (int unsigned s = 1; s < PIPE_STAGES; s++) begin
          vd_q[s]  <= vd_q[s-1];
          vdh_q[s] <= vdh_q[s-1];
          tag_q[s] <= tag_q[s-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_multiply_pipeline.sv
// -----------------------------------------------------------------------------
// tb_vector_multiply_pipeline
//
// Self-checking bench for vector_multiply_pipeline (DATA_WIDTH=64,
// PIPE_STAGES=3, TAG_WIDTH=6). Expected results come from a lane-by-lane
// integer model and from hand-derived constants.
// -----------------------------------------------------------------------------
module tb_vector_multiply_pipeline;

  localparam int DW = 64;
  localparam int S  = 3;
  localparam int TW = 6;

  typedef struct packed {
    logic [1:0]    sew;
    logic [1:0]    sign;
    logic          widen;
    logic          high;
    logic [TW-1:0] tag;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } op_t;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_sew;
  logic [1:0]    in_sign;
  logic          in_widen;
  logic          in_high;
  logic [TW-1:0] in_tag;
  logic [DW-1:0] vs2;
  logic [DW-1:0] vs1;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_vd;
  logic [DW-1:0] out_vd_high;
  logic [TW-1:0] out_tag;

  int n_run;
  int n_fail;

  vector_multiply_pipeline #(
    .DATA_WIDTH (DW),
    .PIPE_STAGES(S),
    .TAG_WIDTH  (TW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sew     (in_sew),
    .in_sign    (in_sign),
    .in_widen   (in_widen),
    .in_high    (in_high),
    .in_tag     (in_tag),
    .vs2        (vs2),
    .vs1        (vs1),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_vd     (out_vd),
    .out_vd_high(out_vd_high),
    .out_tag    (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference: each lane read as a plain integer, multiplied, product bits placed.
  function automatic logic [2*DW-1:0] model(input op_t o);
    logic [2*DW-1:0]    r;
    logic signed [131:0] x;
    logic signed [131:0] y;
    logic signed [131:0] p;
    int w;
    r = '0;
    w = 8 * (1 << o.sew);
    if (o.sign == 2'b11 || w > DW) return r;
    for (int i = 0; i < DW / w; i++) begin
      x = '0;
      y = '0;
      for (int k = 0; k < w; k++) begin
        x[k] = o.a[w*i+k];
        y[k] = o.b[w*i+k];
      end
      if (o.sign != 2'b00 && x[w-1]) x = x - (132'sd1 <<< w);
      if (o.sign == 2'b10 && y[w-1]) y = y - (132'sd1 <<< w);
      p = x * y;
      if (o.widen) begin
        for (int k = 0; k < 2 * w; k++) r[2*w*i+k] = p[k];
      end else begin
        for (int k = 0; k < w; k++) r[w*i+k] = o.high ? p[w+k] : p[k];
      end
    end
    return r;
  endfunction

  function automatic op_t mk_op(input logic [1:0] sew, input logic [1:0] sign,
                                input logic widen, input logic high, input logic [TW-1:0] tag,
                                input logic [DW-1:0] a, input logic [DW-1:0] b);
    op_t o;
    o.sew = sew; o.sign = sign; o.widen = widen; o.high = high;
    o.tag = tag; o.a = a; o.b = b;
    return o;
  endfunction

  function automatic op_t rand_op(input logic [TW-1:0] tag);
    logic [1:0] sg;
    sg = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
    return mk_op(2'($urandom_range(0, 3)), sg, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), tag, {$urandom, $urandom}, {$urandom, $urandom});
  endfunction

  task automatic drive_op(input op_t o);
    in_valid = 1'b1;
    in_sew   = o.sew;
    in_sign  = o.sign;
    in_widen = o.widen;
    in_high  = o.high;
    in_tag   = o.tag;
    vs2      = o.a;
    vs1      = o.b;
  endtask

  // Issue one op into a drained pipe; return what appears and how many extra
  // edges after the accepting edge it took (-1 on timeout).
  task automatic do_op(input op_t o, output logic [DW-1:0] vd, output logic [DW-1:0] vdh,
                       output logic [TW-1:0] tg, output int lat);
    @(posedge clk);
    #1;
    drive_op(o);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        lat = c;
        break;
      end
    end
    vd  = out_vd;
    vdh = out_vd_high;
    tg  = out_tag;
  endtask

  task automatic test_reset();
    n_run++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    n_run++;
    if (out_vd !== '0) begin
      n_fail++; $display("FAIL reset_out_vd: got %h want 0", out_vd);
    end
    n_run++;
    if (out_vd_high !== '0) begin
      n_fail++; $display("FAIL reset_out_vd_high: got %h want 0", out_vd_high);
    end
    n_run++;
    if (out_tag !== '0) begin
      n_fail++; $display("FAIL reset_out_tag: got %h want 0", out_tag);
    end
    n_run++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    op_t           ops[8];
    logic [DW-1:0] ev[8];
    logic [DW-1:0] eh[8];
    logic [DW-1:0] vd;
    logic [DW-1:0] vdh;
    logic [TW-1:0] tg;
    int            lat;
    ops[0] = mk_op(2'b00, 2'b10, 1'b0, 1'b0, 6'd1, '1, 64'h0202_0202_0202_0202);
    ev[0] = 64'hFEFE_FEFE_FEFE_FEFE; eh[0] = '0;
    ops[1] = mk_op(2'b00, 2'b10, 1'b0, 1'b1, 6'd2, '1, 64'h0202_0202_0202_0202);
    ev[1] = 64'hFFFF_FFFF_FFFF_FFFF; eh[1] = '0;
    ops[2] = mk_op(2'b10, 2'b00, 1'b1, 1'b0, 6'd3, '1, '1);
    ev[2] = 64'hFFFF_FFFE_0000_0001; eh[2] = 64'hFFFF_FFFE_0000_0001;
    ops[3] = mk_op(2'b10, 2'b10, 1'b1, 1'b1, 6'd4, '1, '1);
    ev[3] = 64'h0000_0000_0000_0001; eh[3] = 64'h0000_0000_0000_0001;
    ops[4] = mk_op(2'b11, 2'b01, 1'b0, 1'b1, 6'd5, '1, 64'd2);
    ev[4] = 64'hFFFF_FFFF_FFFF_FFFF; eh[4] = '0;
    ops[5] = mk_op(2'b11, 2'b00, 1'b0, 1'b1, 6'd6, '1, 64'd2);
    ev[5] = 64'h0000_0000_0000_0001; eh[5] = '0;
    ops[6] = mk_op(2'b00, 2'b11, 1'b0, 1'b0, 6'd7, '1, '1);
    ev[6] = '0; eh[6] = '0;
    ops[7] = mk_op(2'b11, 2'b11, 1'b1, 1'b0, 6'd8, '1, '1);
    ev[7] = '0; eh[7] = '0;
    for (int i = 0; i < 8; i++) begin
      do_op(ops[i], vd, vdh, tg, lat);
      n_run++;
      if (lat !== S - 1) begin
        n_fail++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, S - 1);
      end
      n_run++;
      if (vd !== ev[i]) begin
        n_fail++; $display("FAIL dir%0d_vd: got %h want %h", i, vd, ev[i]);
      end
      n_run++;
      if (vdh !== eh[i]) begin
        n_fail++; $display("FAIL dir%0d_vd_high: got %h want %h", i, vdh, eh[i]);
      end
      n_run++;
      if (tg !== ops[i].tag) begin
        n_fail++; $display("FAIL dir%0d_tag: got %h want %h", i, tg, ops[i].tag);
      end
    end
  endtask

  task automatic test_back_to_back();
    op_t             ops[6];
    logic [2*DW-1:0] e;
    logic [DW-1:0]   h_vd;
    logic [DW-1:0]   h_vdh;
    logic [TW-1:0]   h_tag;
    logic            held;
    int              sent;
    int              got;
    int              first_c;
    for (int i = 0; i < 6; i++) ops[i] = rand_op(TW'(i));
    sent = 0; got = 0; first_c = -1; held = 1'b0;
    @(posedge clk);
    for (int c = 0; c < 40 && got < 6; c++) begin
      #1;
      if (sent < 6) drive_op(ops[sent]);
      else in_valid = 1'b0;
      out_ready = !(c >= S + 1 && c <= S + 3);
      @(negedge clk);
      if (held) begin
        n_run++;
        if (out_valid !== 1'b1 || out_vd !== h_vd || out_vd_high !== h_vdh || out_tag !== h_tag)
        begin
          n_fail++;
          $display("FAIL b2b_hold: got v=%b tag=%h vd=%h want v=1 tag=%h vd=%h",
                   out_valid, out_tag, out_vd, h_tag, h_vd);
        end
      end
      if (out_valid === 1'b1 && !out_ready) begin
        n_run++;
        if (in_ready !== 1'b0) begin
          n_fail++; $display("FAIL b2b_in_ready_stall: got %b want 0", in_ready);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        if (first_c < 0) first_c = c;
        n_run++;
        if (got >= 6) begin
          n_fail++; $display("FAIL b2b_extra: got tag %h want no result", out_tag);
        end else begin
          e = model(ops[got]);
          if (out_tag !== TW'(got) || {out_vd_high, out_vd} !== e) begin
            n_fail++;
            $display("FAIL b2b_result%0d: got tag=%h %h_%h want tag=%h %h_%h", got, out_tag,
                     out_vd_high, out_vd, TW'(got), e[2*DW-1:DW], e[DW-1:0]);
          end
        end
        got++;
      end
      held  = (out_valid === 1'b1) && !out_ready;
      h_vd  = out_vd;
      h_vdh = out_vd_high;
      h_tag = out_tag;
      if (in_valid && in_ready === 1'b1) sent++;
      @(posedge clk);
    end
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_run++;
    if (got !== 6) begin
      n_fail++; $display("FAIL b2b_count: got %0d results want 6", got);
    end
    n_run++;
    if (first_c !== S) begin
      n_fail++; $display("FAIL b2b_first_latency: got cycle %0d want %0d", first_c, S);
    end
  endtask

  task automatic test_flush();
    op_t             o;
    logic [2*DW-1:0] e;
    logic [DW-1:0]   vd;
    logic [DW-1:0]   vdh;
    logic [TW-1:0]   tg;
    int              lat;
    int              seen;
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      #1;
      drive_op(rand_op(TW'(10 + c)));
      out_ready = 1'b1;
      @(posedge clk);
    end
    #1;
    drive_op(rand_op(6'd13));
    flush     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    n_run++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_next_cycle: got out_valid=%b want 0", out_valid);
    end
    seen = 0;
    for (int c = 0; c < S + 3; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    n_run++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL flush_drain: got %0d valid cycles want 0", seen);
    end
    o = mk_op(2'b01, 2'b10, 1'b1, 1'b0, 6'd20, {$urandom, $urandom}, {$urandom, $urandom});
    e = model(o);
    do_op(o, vd, vdh, tg, lat);
    n_run++;
    if (lat !== S - 1) begin
      n_fail++; $display("FAIL flush_after_latency: got %0d want %0d", lat, S - 1);
    end
    n_run++;
    if ({vdh, vd} !== e || tg !== 6'd20) begin
      n_fail++;
      $display("FAIL flush_after_result: got tag=%h %h_%h want tag=14 %h_%h", tg, vdh, vd,
               e[2*DW-1:DW], e[DW-1:0]);
    end
  endtask

  task automatic test_random();
    logic [TW+2*DW-1:0] q[$];
    logic [TW+2*DW-1:0] e;
    logic [DW-1:0]      h_vd;
    logic [DW-1:0]      h_vdh;
    logic [TW-1:0]      h_tag;
    logic               held;
    logic               have;
    op_t                pend;
    int                 next_tag;
    held = 1'b0; have = 1'b0; next_tag = 0;
    @(posedge clk);
    for (int c = 0; c < 400 + 60; c++) begin
      #1;
      if (c < 400) begin
        if (!have && $urandom_range(0, 3) != 0) begin
          pend = rand_op(TW'(next_tag));
          next_tag++;
          have = 1'b1;
        end
        if (have) drive_op(pend);
        else in_valid = 1'b0;
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      @(negedge clk);
      if (held) begin
        n_run++;
        if (out_valid !== 1'b1 || out_vd !== h_vd || out_vd_high !== h_vdh || out_tag !== h_tag)
        begin
          n_fail++;
          $display("FAIL rand_hold: got v=%b tag=%h vd=%h want v=1 tag=%h vd=%h", out_valid,
                   out_tag, out_vd, h_tag, h_vd);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        n_run++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rand_unexpected: got tag %h want nothing", out_tag);
        end else begin
          e = q.pop_front();
          if ({out_tag, out_vd_high, out_vd} !== e) begin
            n_fail++;
            $display("FAIL rand_result: got tag=%h %h_%h want tag=%h %h_%h", out_tag,
                     out_vd_high, out_vd, e[TW+2*DW-1:2*DW], e[2*DW-1:DW], e[DW-1:0]);
          end
        end
      end
      if (in_valid && in_ready === 1'b1) begin
        q.push_back({pend.tag, model(pend)});
        have = 1'b0;
      end
      held  = (out_valid === 1'b1) && !out_ready;
      h_vd  = out_vd;
      h_vdh = out_vd_high;
      h_tag = out_tag;
      @(posedge clk);
    end
    n_run++;
    if (q.size() != 0) begin
      n_fail++; $display("FAIL rand_drain: got %0d ops left want 0", q.size());
    end
  endtask

  task automatic test_async_reset();
    op_t             o;
    logic [2*DW-1:0] e;
    logic [DW-1:0]   vd;
    logic [DW-1:0]   vdh;
    logic [TW-1:0]   tg;
    int              lat;
    o = mk_op(2'b00, 2'b00, 1'b1, 1'b0, 6'd33, '1, '1);
    @(posedge clk);
    #1;
    drive_op(o);
    out_ready = 1'b0;
    repeat (S + 1) @(posedge clk);
    @(negedge clk);
    n_run++;
    if (out_valid !== 1'b1 || out_tag !== 6'd33 || out_vd !== 64'hFE01_FE01_FE01_FE01) begin
      n_fail++;
      $display("FAIL areset_pre: got v=%b tag=%h vd=%h want v=1 tag=21 vd=fe01fe01fe01fe01",
               out_valid, out_tag, out_vd);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_run++;
    if (out_valid !== 1'b0 || out_vd !== '0 || out_vd_high !== '0 || out_tag !== '0) begin
      n_fail++;
      $display("FAIL areset_immediate: got v=%b vd=%h vdh=%h tag=%h want all 0", out_valid,
               out_vd, out_vd_high, out_tag);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    n_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_release: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    o = mk_op(2'b01, 2'b01, 1'b0, 1'b0, 6'd34, {$urandom, $urandom}, {$urandom, $urandom});
    e = model(o);
    do_op(o, vd, vdh, tg, lat);
    n_run++;
    if (lat !== S - 1 || {vdh, vd} !== e || tg !== 6'd34) begin
      n_fail++;
      $display("FAIL areset_after: got lat=%0d tag=%h %h_%h want lat=%0d tag=22 %h_%h", lat, tg,
               vdh, vd, S - 1, e[2*DW-1:DW], e[DW-1:0]);
    end
  endtask

  initial begin
    n_run     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_sew    = '0;
    in_sign   = '0;
    in_widen  = 1'b0;
    in_high   = 1'b0;
    in_tag    = '0;
    vs2       = '0;
    vs1       = '0;
    #22;
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
